uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NREQ byte requesters using round-robin arbitration.
- A lock option lets one requester keep ownership so a multi-byte message (e.g. an echoed string) goes out uninterrupted.
- Sits between the lab datapath clients (echo path, status reporter, etc.) and the UART tx side (txen/din/txready).
- Sequences each byte through load, wait-busy and wait-done phases, with a watchdog on the UART handshake.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 15, max cycles to wait for uart_txready to fall after uart_txen before flagging an error.

Ports:
- clock  in  1  master clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; bit i high = requester i has a byte on its din slice.
- din  in  8*NREQ  data; byte i is din[8*i+7:8*i].
- lock  in  NREQ  per-requester lock; sampled only for the current owner.
- ack  out  NREQ  one-cycle pulse: byte i captured; requester may change data or drop req next cycle.
- grant  out  NREQ  one-hot current owner, or 0 when no owner.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on watchdog expiry.
- uart_txen  out  1  one-cycle load strobe to the UART.
- uart_din  out  8  byte to the UART; held stable from the txen cycle until the next load.
- uart_txready  in  1  high when the UART can accept a byte; drops after txen and rises at end of frame.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE; ack, grant, busy, err, uart_txen = 0; uart_din=8'h00; watchdog counter=0.
  - Priority pointer last=NREQ-1, so requester 0 has highest priority after reset.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE, eligible set:
  - If grant!=0 and lock[owner]=1: eligible = {owner} only; other requests are blocked.
  - If grant!=0 and lock[owner]=0: ownership released (grant<=0) and arbitration runs over all req in the same cycle.
  - Otherwise: eligible = all req.
- IDLE, action: when uart_txready=1 and an eligible req is high:
  - Winner = first set bit scanning from (last+1) mod NREQ upward, wrapping.
  - Next edge: grant<=onehot(winner), uart_din<=din byte of winner, ack[winner]<=1, uart_txen<=1, last<=winner, counter<=0, state<=WAIT_BUSY.
  - Latency from sampled req to txen/ack is 1 cycle.
  - When uart_txready=0 in IDLE, no grant is issued and state stays IDLE.
- WAIT_BUSY:
  - ack and uart_txen return to 0 (both are exactly one cycle wide).
  - uart_txready=0 -> WAIT_DONE.
  - Otherwise counter++; when counter reaches BUSY_TIMEOUT: err pulse, grant<=0, state<=IDLE (ownership dropped even if locked).
- WAIT_DONE: uart_txready=1 -> IDLE. grant is retained (ownership is re-evaluated in IDLE). No timeout in this state.
- Back-to-back bytes: the minimum gap between txen pulses is the UART frame time plus 2 cycles (IDLE plus load).
- Simultaneous events:
  - A req that rises in the same cycle another is granted waits its turn.
  - A req that drops in the same cycle its ack pulses has no effect; the byte is already captured.
  - lock rising on a non-owner is ignored.
- Owner drops req while holding lock: grant stays asserted and everyone else is blocked until lock falls. This is intentional; clients must release lock.
- din of non-granted requesters is never sampled.

Test Plan:
- Single requester: NREQ=4, req[2]=1, din byte2=8'h61 after reset -> exactly one txen pulse; uart_din=8'h61; ack=4'b0100 in the same cycle; grant=4'b0100; busy high until txready rises, then busy low.
- Fairness: req=4'b1111 held continuously with bytes "A","B","C","D" at indices 0..3 -> transmit order 0,1,2,3,0,1 over six frames; each ack is exactly one cycle; no index is served twice in a row.
- Lock:
  - lock[1]=1 and req[1]=1 for 3 bytes "x","y","z", with req[0]=1 and req[3]=1 pending -> "x","y","z" sent consecutively with grant=4'b0010 throughout.
  - After lock[1] drops -> next grant goes to requester 3, then requester 0.
- Watchdog: UART model keeps txready stuck at 1 after txen -> err pulses exactly BUSY_TIMEOUT+1 cycles after txen; state returns to IDLE; grant=0; the next request is serviced normally.
- Reset mid-op: assert reset during WAIT_DONE with grant=4'b1000 -> all outputs 0 immediately (asynchronously); after release, req=4'b1001 -> requester 0 is granted first.
- Txready low in IDLE: hold uart_txready=0 with req=4'b0001 -> no txen or ack; when txready rises -> txen exactly 1 cycle later.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester-side and UART-side handshake signals of the
// round-robin UART transmit arbiter.
//   req          : per-requester request level
//   din          : per-requester data byte (byte i at din[i], i.e. bits 8*i+7:8*i)
//   lock         : per-requester ownership lock (only the owner's bit matters)
//   ack          : one-cycle pulse, byte i captured
//   grant        : one-hot current owner, 0 when nobody owns the UART
//   busy         : arbiter is in a byte-sequencing state
//   err          : one-cycle pulse when the UART never went busy after a load
//   uart_txen    : one-cycle load strobe to the UART
//   uart_din     : byte to the UART, stable from txen until the next load
//   uart_txready : UART can accept a byte
// Modports: slave = arbiter side, master = clients + UART side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0][7:0] din;
    logic [NREQ-1:0]      lock;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 err;
    logic                 uart_txen;
    logic [7:0]           uart_din;
    logic                 uart_txready;

    modport slave (
        input  req, din, lock, uart_txready,
        output ack, grant, busy, err, uart_txen, uart_din
    );

    modport master (
        output req, din, lock, uart_txready,
        input  ack, grant, busy, err, uart_txen, uart_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NREQ byte requesters with round-robin
// arbitration. An owner holding its lock bit keeps the UART across bytes so
// a multi-byte message is not interleaved with other clients.
// Each byte goes IDLE (arbitrate + load) -> WAIT_BUSY (UART must drop
// txready, watchdog running) -> WAIT_DONE (UART raises txready at frame end).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : uart_tx_arbiter_if.slave (requesters and UART handshake)
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q,   ack_d;
    logic [IW-1:0]     last_q,  last_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [7:0]        din_q,   din_d;
    logic              txen_q,  txen_d;
    logic              err_q,   err_d;

    // arbitration helpers
    logic              owner_locked;
    logic [NREQ-1:0]   eligible;
    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [NREQ-1:0]   win_onehot;
    int                scan_idx;

    // Lock only counts when it belongs to the current owner; a lock bit on
    // any other requester is ignored.
    assign owner_locked = |(grant_q & bus.lock);
    assign eligible     = owner_locked ? (bus.req & grant_q) : bus.req;

    // Round-robin pick: first eligible bit starting just after the last
    // winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = (int'(last_q) + k) % NREQ;
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_idx);
            end
        end
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        ack_d   = '0;
        txen_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // An unlocked owner gives up the UART here; arbitration in
                // the same cycle may hand it straight back.
                if (!owner_locked) begin
                    grant_d = '0;
                end
                if (bus.uart_txready && win_found) begin
                    grant_d = win_onehot;
                    ack_d   = win_onehot;
                    din_d   = bus.din[win_idx];
                    txen_d  = 1'b1;
                    last_d  = win_idx;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end
            end

            WAIT_BUSY: begin
                if (!bus.uart_txready) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
                    // UART never took the byte: drop ownership even if
                    // locked so one stuck client cannot wedge the others.
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            WAIT_DONE: begin
                // Ownership is kept; IDLE decides whether it survives.
                if (bus.uart_txready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
            din_q   <= 8'h00;
            txen_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            txen_q  <= txen_d;
            err_q   <= err_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
    assign bus.uart_txen = txen_q;
    assign bus.uart_din  = din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. Client processes present queued
// bytes, a UART model answers txen, a transaction-level model predicts the
// transmit order into a scoreboard, and a monitor checks every load.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int BT   = 15;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_err = 0;
    int   m_last = NREQ - 1;

    // client byte queues
    logic [7:0] cbuf [NREQ][32];
    int         chead [NREQ] = '{default: 0};
    int         ctail [NREQ] = '{default: 0};
    bit         lockf [NREQ] = '{default: 0};

    // UART model controls
    logic uart_rdy = 1'b1;
    bit   hold_low = 1'b0;
    bit   stuck = 1'b0;
    bit   long_frame = 1'b0;
    int   ust = 0;
    int   ucnt = 0;

    assign bus.uart_txready = uart_rdy & ~hold_low;

    task automatic chk(input string nm, input bit ok, input string det);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", nm, det);
        end
    endtask

    function automatic bit clients_empty();
        for (int i = 0; i < NREQ; i++)
            if (chead[i] != ctail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_byte(input int i, input logic [7:0] b);
        if (chead[i] == ctail[i]) begin
            chead[i] = 0;
            ctail[i] = 0;
        end
        cbuf[i][ctail[i]] = b;
        ctail[i]++;
    endtask

    // Reference model: repeatedly serve the first client with bytes left
    // after the previous winner; a locked client drains its whole message.
    task automatic plan();
        int   rem [NREQ];
        int   pos [NREQ];
        int   total;
        int   w;
        int   n;
        int   j;
        exp_t e;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = ctail[i] - chead[i];
            pos[i] = chead[i];
            total += rem[i];
        end
        while (total > 0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                j = (m_last + k) % NREQ;
                if (w < 0 && rem[j] > 0) w = j;
            end
            n = lockf[w] ? rem[w] : 1;
            for (int c = 0; c < n; c++) begin
                e.idx  = w;
                e.data = cbuf[w][pos[w]];
                sb.push_back(e);
                pos[w]++;
                rem[w]--;
                total--;
            end
            m_last = w;
        end
    endtask

    task automatic wait_done(input string nm);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < 3000 && !ok) begin
            @(negedge clock);
            n++;
            ok = (sb.size() == 0) && (exp_err == 0) && !bus.busy && clients_empty();
        end
        chk(nm, ok, $sformatf("phase timeout pending=%0d busy=%b", sb.size(), bus.busy));
        repeat (2) @(negedge clock);
    endtask

    // Clients: pop on ack, then present the next byte. Idle clients drive
    // random din so any stray sampling shows up as a data miscompare.
    always @(negedge clock) begin : clients
        logic [NREQ-1:0]      r;
        logic [NREQ-1:0]      l;
        logic [NREQ-1:0][7:0] d;
        r = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!reset && bus.ack[i] && chead[i] != ctail[i]) chead[i]++;
            if (chead[i] != ctail[i]) begin
                r[i] = 1'b1;
                d[i] = cbuf[i][chead[i]];
                l[i] = lockf[i];
            end else begin
                d[i] = 8'($urandom);
            end
        end
        bus.req  = r;
        bus.din  = d;
        bus.lock = l;
    end

    // UART model: drops txready a few cycles after txen, raises it at the
    // end of the frame. In stuck mode it ignores txen entirely.
    always @(negedge clock or posedge reset) begin : uart_model
        if (reset) begin
            uart_rdy = 1'b1;
            ust      = 0;
            ucnt     = 0;
        end else begin
            case (ust)
                0: if (bus.uart_txen && !stuck) begin
                    ucnt = $urandom_range(0, 3);
                    ust  = 1;
                end
                1: if (ucnt == 0) begin
                    uart_rdy = 1'b0;
                    ucnt     = long_frame ? 40 : $urandom_range(2, 8);
                    ust      = 2;
                end else ucnt--;
                default: if (ucnt == 0) begin
                    uart_rdy = 1'b1;
                    ust      = 0;
                end else ucnt--;
            endcase
        end
    end

    // Monitor
    longint          cyc = 0;
    longint          txen_cyc = -100;
    bit              prev_txen = 1'b0;
    bit              prev_err = 1'b0;
    exp_t            mon_e;
    logic [NREQ-1:0] mon_oh;

    always @(negedge clock) begin : monitor
        cyc++;
        if (reset) begin
            prev_txen = 1'b0;
            prev_err  = 1'b0;
        end else begin
            tests++;
            if (((bus.ack != '0) != bus.uart_txen) || (bus.uart_txen && prev_txen)) begin
                fails++;
                $display("FAIL ack_txen_pulse: ack=%b txen=%b prev_txen=%b, want ack only with single-cycle txen",
                         bus.ack, bus.uart_txen, prev_txen);
            end
            if (bus.uart_txen) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL txn: unexpected txen grant=%b din=%h", bus.grant, bus.uart_din);
                end else begin
                    mon_e              = sb.pop_front();
                    mon_oh             = '0;
                    mon_oh[mon_e.idx]  = 1'b1;
                    if (bus.grant !== mon_oh || bus.ack !== mon_oh ||
                        bus.uart_din !== mon_e.data || bus.busy !== 1'b1) begin
                        fails++;
                        $display("FAIL txn: grant=%b ack=%b din=%h busy=%b, want grant=ack=%b din=%h busy=1",
                                 bus.grant, bus.ack, bus.uart_din, bus.busy, mon_oh, mon_e.data);
                    end
                end
                txen_cyc = cyc;
            end
            if (bus.err) begin
                tests++;
                if (exp_err == 0 || prev_err || (cyc - txen_cyc) != BT + 1 ||
                    bus.grant != '0 || bus.busy) begin
                    fails++;
                    $display("FAIL err: expected=%0d delay=%0d grant=%b busy=%b, want delay=%0d grant=0 busy=0",
                             exp_err, cyc - txen_cyc, bus.grant, bus.busy, BT + 1);
                end
                if (exp_err > 0) exp_err--;
            end
            prev_txen = bus.uart_txen;
            prev_err  = bus.err;
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  n;
        bit  seen;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_state",
            bus.grant == '0 && bus.ack == '0 && !bus.busy && !bus.err && !bus.uart_txen && bus.uart_din == 8'h00,
            $sformatf("grant=%b ack=%b busy=%b err=%b txen=%b din=%h, want all zero",
                      bus.grant, bus.ack, bus.busy, bus.err, bus.uart_txen, bus.uart_din));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // single requester
        @(posedge clock); #1;
        push_byte(2, 8'h61);
        plan();
        wait_done("single");
        chk("single_release", bus.grant == '0 && !bus.busy,
            $sformatf("grant=%b busy=%b, want 0 0", bus.grant, bus.busy));

        // fairness: all four requesting, two bytes each
        @(posedge clock); #1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push_byte(i, 8'h41 + 8'(i));
        plan();
        wait_done("fairness");

        // lock: set last winner to 0, then locked message from client 1
        @(posedge clock); #1;
        push_byte(0, 8'h30);
        plan();
        wait_done("lock_pre");
        @(posedge clock); #1;
        lockf[1] = 1'b1;
        push_byte(1, 8'h78);
        push_byte(1, 8'h79);
        push_byte(1, 8'h7a);
        push_byte(0, 8'h31);
        push_byte(3, 8'h33);
        plan();
        wait_done("lock");
        lockf[1] = 1'b0;

        // watchdog: UART never drops txready
        @(posedge clock); #1;
        stuck = 1'b1;
        push_byte(2, 8'hc3);
        plan();
        exp_err = 1;
        wait_done("watchdog");
        chk("watchdog_idle", bus.grant == '0 && !bus.busy,
            $sformatf("grant=%b busy=%b, want 0 0", bus.grant, bus.busy));
        stuck = 1'b0;
        @(posedge clock); #1;
        push_byte(1, 8'h5b);
        plan();
        wait_done("after_watchdog");

        // txready low in IDLE blocks the load
        @(posedge clock); #1;
        hold_low = 1'b1;
        push_byte(0, 8'h11);
        plan();
        repeat (6) begin
            @(negedge clock);
            chk("ready_low_hold", !bus.uart_txen && bus.ack == '0,
                $sformatf("txen=%b ack=%b, want 0 0", bus.uart_txen, bus.ack));
        end
        hold_low = 1'b0;
        @(negedge clock);
        chk("ready_rise_latency", bus.uart_txen === 1'b1,
            $sformatf("txen=%b one cycle after txready rose, want 1", bus.uart_txen));
        wait_done("ready_low");

        // randomized phases
        for (int p = 0; p < 25; p++) begin
            @(posedge clock); #1;
            for (int i = 0; i < NREQ; i++) begin
                n        = $urandom_range(0, 3);
                lockf[i] = ($urandom_range(0, 3) == 0);
                for (int b = 0; b < n; b++) push_byte(i, 8'($urandom));
            end
            plan();
            wait_done($sformatf("random_%0d", p));
        end
        for (int i = 0; i < NREQ; i++) lockf[i] = 1'b0;

        // reset in WAIT_DONE with requester 3 owning the UART
        @(posedge clock); #1;
        long_frame = 1'b1;
        push_byte(3, 8'h5a);
        plan();
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(posedge clock);
            n++;
            seen = (ust == 2);
        end
        chk("midop_reach", seen && bus.grant == 4'b1000,
            $sformatf("in_frame=%b grant=%b, want 1 1000", seen, bus.grant));
        #2 reset = 1'b1;
        #1;
        chk("reset_async",
            bus.grant == '0 && bus.ack == '0 && !bus.busy && !bus.err && !bus.uart_txen && bus.uart_din == 8'h00,
            $sformatf("grant=%b ack=%b busy=%b err=%b txen=%b din=%h, want all zero",
                      bus.grant, bus.ack, bus.busy, bus.err, bus.uart_txen, bus.uart_din));
        for (int i = 0; i < NREQ; i++) chead[i] = ctail[i];
        sb.delete();
        exp_err    = 0;
        m_last     = NREQ - 1;
        long_frame = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        push_byte(0, 8'ha0);
        push_byte(3, 8'ha3);
        plan();
        wait_done("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
